// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Channel index width, kept at least one bit wide.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_CH.
module rr_picker #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [CW-1:0]     gnt_idx,
  output logic              gnt_any
);

  int idx;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx[CW-1:0]]) begin
        gnt_idx = idx[CW-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler draining NUM_CH FWFT FIFOs into one valid/ready
// stream, with a per-grant burst limit and a one-cycle bubble per grant.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  output logic [NUM_CH-1:0]            ch_read_en,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ch_w(NUM_CH)-1:0]      out_ch,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int CW = ch_w(NUM_CH);
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_t      state;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   cur_ch;
  logic [BW-1:0]   burst_cnt;

  logic [NUM_CH-1:0]     eligible;
  logic [DATA_WIDTH-1:0] ch_words [NUM_CH];
  logic [DATA_WIDTH-1:0] cur_data;
  logic [CW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic                  can_load;
  logic                  pop;
  logic                  burst_last;
  logic [CW-1:0]         next_ptr;

  assign eligible = ch_enable & ~ch_empty;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_words[gi] = ch_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    // Gated by reset so the pop strobe falls in the same instant as the FSM.
    assign ch_read_en[gi] = pop && !reset && (cur_ch == CW'(gi));
  end

  assign cur_data   = ch_words[cur_ch];
  assign can_load   = !out_valid || out_ready;
  assign pop        = (state == SERVE) && can_load && eligible[cur_ch];
  assign burst_last = (burst_cnt == BW'(BURST_MAX - 1));
  assign next_ptr   = (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + CW'(1);
  assign busy       = (state == SERVE) || out_valid;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_picker (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      // Output register: load on pop, otherwise empty once the word is taken.
      if (pop) begin
        out_data  <= cur_data;
        out_ch    <= cur_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_ch    <= gnt_idx;
            burst_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          // Release on drain/disable takes priority and never coincides with a pop.
          if (!eligible[cur_ch]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (pop) begin
            burst_cnt <= burst_cnt + BW'(1);
            if (burst_last) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: FWFT FIFO models, table-driven scenarios, and a
// scoreboard of expected {channel, word} pairs filled from the stimulus.
module tb_fifo_read_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NCH-1:0]  ch_enable = '1;
  logic [NCH-1:0]  ch_empty = '1;
  logic [NCH*DW-1:0] ch_rdata = '0;
  logic [NCH-1:0]  ch_read_en;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_ready = 1'b1;
  logic            busy;

  fifo_read_arbiter #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .BURST_MAX  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .ch_empty   (ch_empty),
    .ch_rdata   (ch_rdata),
    .ch_read_en (ch_read_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]      en;
    logic [3:0][3:0] cnt;   // cnt[i] = words loaded into channel i
    string           seq;   // expected channel order of delivered words
    bit              rnd;   // randomise out_ready
  } row_t;

  exp_t       exp_q[$];
  logic [7:0] mem [NCH][DEPTH];
  int         wr [NCH];
  int         rd [NCH];
  int         pop_cnt [NCH];
  int         exp_idx [NCH];
  bit         rand_ready = 1'b0;
  logic [3:0] last_pop;
  logic       obs_valid, obs_busy;
  logic [7:0] obs_data;
  int         n_pass = 0;
  int         n_total = 0;
  row_t       rows[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic update_io();
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i] = (rd[i] == wr[i]);
      ch_rdata[i*DW +: DW] = mem[i][rd[i] % DEPTH];
    end
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wr[c]] = 8'(c * 16 + wr[c] + 1);
      wr[c]++;
    end
    update_io();
  endtask

  task automatic push_seq(input string s);
    exp_t e;
    int c;
    for (int k = 0; k < s.len(); k++) begin
      c = int'(s[k]) - 48;
      e.ch = 2'(c);
      e.data = 8'(c * 16 + exp_idx[c] + 1);
      exp_idx[c]++;
      exp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NCH; i++) begin
      wr[i] = 0; rd[i] = 0; pop_cnt[i] = 0; exp_idx[i] = 0;
      for (int k = 0; k < DEPTH; k++) mem[i][k] = '0;
    end
    exp_q.delete();
    update_io();
  endtask

  // One clock: observe at the falling edge, then apply FIFO pops after the rising edge.
  task automatic cycle();
    logic [3:0] pm;
    exp_t e;
    @(negedge clk);
    pm = ch_read_en;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_busy  = busy;
    if (pm != 0) begin
      check("pop_onehot", $countones(pm), 1);
      for (int i = 0; i < NCH; i++)
        if (pm[i]) check("pop_eligible", {31'b0, ch_enable[i] && !ch_empty[i]}, 1);
    end
    last_pop = pm;
    if (out_valid && out_ready) begin
      check("sb_nonempty", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_ch", out_ch, e.ch);
        check("out_data", out_data, e.data);
      end
      $display("xfer ch=%0d data=%02h", out_ch, out_data);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++)
      if (pm[i]) begin rd[i]++; pop_cnt[i]++; end
    update_io();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      cycle();
      n++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy"}, {31'b0, busy}, 0);
    out_ready = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    ch_enable = '1;
    flush();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int c, input int n);
    int k = 0;
    while (pop_cnt[c] < n && k < 200) begin
      cycle();
      k++;
    end
    check("pop_wait", pop_cnt[c], n);
  endtask

  logic [3:0] b_re    [6];
  logic       b_valid [6];
  logic [7:0] b_data  [6];
  logic       b_busy  [6];

  initial begin
    rows[0] = '{en: 4'hF, cnt: {4'd0, 4'd0, 4'd0, 4'd3}, seq: "000", rnd: 1'b0};
    rows[1] = '{en: 4'hF, cnt: {4'd6, 4'd6, 4'd6, 4'd6}, seq: "000011112222333300112233", rnd: 1'b0};
    rows[2] = '{en: 4'hF, cnt: {4'd6, 4'd6, 4'd6, 4'd6}, seq: "000011112222333300112233", rnd: 1'b1};
    rows[3] = '{en: 4'hF, cnt: {4'd2, 4'd5, 4'd0, 4'd1}, seq: "02222332", rnd: 1'b1};
    rows[4] = '{en: 4'b1010, cnt: {4'd3, 4'd3, 4'd3, 4'd3}, seq: "111333", rnd: 1'b0};
    rows[5] = '{en: 4'hF, cnt: {4'd0, 4'd1, 4'd4, 4'd0}, seq: "11112", rnd: 1'b0};

    // Reset state, with a word waiting so the pop gate is exercised.
    flush();
    load(0, 2);
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en", ch_read_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_busy", busy, 0);

    // Table-driven scenarios.
    for (int r = 0; r < 6; r++) begin
      int occ;
      reset_dut();
      ch_enable = rows[r].en;
      rand_ready = rows[r].rnd;
      for (int c = 0; c < NCH; c++) load(c, int'(rows[r].cnt[c]));
      push_seq(rows[r].seq);
      drain($sformatf("row%0d", r));
      for (int c = 0; c < NCH; c++) begin
        occ = 0;
        for (int k = 0; k < rows[r].seq.len(); k++)
          if (int'(rows[r].seq[k]) - 48 == c) occ++;
        check($sformatf("row%0d_left%0d", r, c), wr[c] - rd[c], int'(rows[r].cnt[c]) - occ);
      end
    end

    // Single channel cycle timing: one bubble, then three back-to-back words.
    b_re    = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    b_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    b_data  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    b_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset_dut();
    load(0, 3);
    push_seq("000");
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("bubble_re%0d", k), last_pop, b_re[k]);
      check($sformatf("bubble_v%0d", k), obs_valid, b_valid[k]);
      if (b_valid[k]) check($sformatf("bubble_d%0d", k), obs_data, b_data[k]);
      check($sformatf("bubble_busy%0d", k), obs_busy, b_busy[k]);
    end
    check("bubble_pending", exp_q.size(), 0);

    // Backpressure mid-burst: output frozen, no pops, nothing lost.
    begin
      logic [7:0] held;
      reset_dut();
      load(0, 6);
      push_seq("000000");
      wait_pops(0, 3);
      out_ready = 1'b0;
      held = out_data;
      check("bp_valid_at_hold", out_valid, 1);
      repeat (5) begin
        cycle();
        check("bp_no_pop", last_pop, 0);
        check("bp_stable", obs_data, held);
        check("bp_valid", obs_valid, 1);
      end
      out_ready = 1'b1;
      drain("bp");
    end

    // Wrap: ch1 served first leaves rr_ptr at 2, so ch3 must precede ch1.
    reset_dut();
    load(1, 1);
    push_seq("1");
    drain("wrap_pre");
    load(3, 2);
    load(1, 2);
    push_seq("3311");
    drain("wrap");

    // Disable the current channel after two pops.
    reset_dut();
    load(0, 6);
    load(1, 6);
    push_seq("00");
    wait_pops(0, 2);
    ch_enable[0] = 1'b0;
    push_seq("111111");
    drain("dis");
    check("dis_pops0", pop_cnt[0], 2);
    check("dis_left0", wr[0] - rd[0], 4);

    // Reset mid-burst on ch3: in-flight word dropped, restart from ch0.
    reset_dut();
    load(2, 1);
    push_seq("2");
    drain("mrst_pre");
    load(0, 6);
    load(3, 6);
    push_seq("3");
    wait_pops(3, 2);
    reset = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_read_en", ch_read_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_delivered", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_idx[3] = 2;
    push_seq("0000333300");
    drain("mrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
